// File: rtl/gray_step_checker_if.sv
// rtl/gray_step_checker_if.sv - sample/status bundle between a Gray counter source and its step checker
interface gray_step_checker_if #(
    parameter int WIDTH      = 4,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 8
);
    logic [WIDTH-1:0]      gray_in;
    logic                  sample_en;
    logic                  clear_err;
    logic [WIDTH-1:0]      bin_out;
    logic                  bin_valid;
    logic                  step_err;
    logic                  err_sticky;
    logic [ERR_CNT_W-1:0]  err_count;
    logic [WRAP_CNT_W-1:0] wrap_count;
    logic [1:0]            state;

    modport master (
        output gray_in, sample_en, clear_err,
        input  bin_out, bin_valid, step_err, err_sticky, err_count, wrap_count, state
    );

    modport slave (
        input  gray_in, sample_en, clear_err,
        output bin_out, bin_valid, step_err, err_sticky, err_count, wrap_count, state
    );
endinterface

// File: rtl/gray_step_checker.sv
// rtl/gray_step_checker.sv - Gray sample decoder checking every transition is a single forward step
module gray_step_checker #(
    parameter int WIDTH      = 4,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    gray_step_checker_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10,
        ST_BAD   = 2'b11
    } state_t;

    state_t                st;
    logic [WIDTH-1:0]      prev_gray;
    logic [WIDTH-1:0]      bin_q;
    logic                  valid_q;
    logic                  step_err_q;
    logic                  sticky_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q;
    logic [WRAP_CNT_W-1:0] wrap_cnt_q;

    logic [WIDTH-1:0]      bin_now;
    logic [WIDTH-1:0]      bin_fwd;
    logic                  changed;
    logic                  is_err;
    logic                  is_wrap;

    // bin_q always holds the decode of the previous sample, so it doubles as prev_bin.
    always_comb begin
        bin_now            = '0;
        bin_now[WIDTH-1]   = bus.gray_in[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin_now[i] = bin_now[i+1] ^ bus.gray_in[i];
        end
        bin_fwd = bin_q + WIDTH'(1);
        changed = (bus.gray_in != prev_gray);
        is_err  = changed && (($countones(bus.gray_in ^ prev_gray) != 1) || (bin_now != bin_fwd));
        is_wrap = changed && !is_err && (bin_q == {WIDTH{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= ST_INIT;
            prev_gray  <= '0;
            bin_q      <= '0;
            valid_q    <= 1'b0;
            step_err_q <= 1'b0;
            sticky_q   <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
        end else begin
            valid_q    <= 1'b0;
            step_err_q <= 1'b0;
            if (st == ST_BAD) begin
                st <= ST_INIT;
            end else begin
                if (bus.clear_err) begin
                    err_cnt_q <= '0;
                    sticky_q  <= 1'b0;
                    if (st == ST_FAULT) st <= ST_TRACK;
                end
                // Later assignments below win, giving "clear first, then count".
                if (bus.sample_en) begin
                    prev_gray <= bus.gray_in;
                    bin_q     <= bin_now;
                    valid_q   <= 1'b1;
                    if (st == ST_INIT) begin
                        st <= ST_TRACK;
                    end else if (is_err) begin
                        step_err_q <= 1'b1;
                        sticky_q   <= 1'b1;
                        st         <= ST_FAULT;
                        if (bus.clear_err)
                            err_cnt_q <= ERR_CNT_W'(1);
                        else if (err_cnt_q != {ERR_CNT_W{1'b1}})
                            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                    end else if (is_wrap) begin
                        wrap_cnt_q <= wrap_cnt_q + WRAP_CNT_W'(1);
                    end
                end
            end
        end
    end

    assign bus.bin_out    = bin_q;
    assign bus.bin_valid  = valid_q;
    assign bus.step_err   = step_err_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_count  = err_cnt_q;
    assign bus.wrap_count = wrap_cnt_q;
    assign bus.state      = st;
endmodule

// File: tb/tb_gray_step_checker.sv
// tb/tb_gray_step_checker.sv - randomized and directed bench for gray_step_checker with an integer reference model
module tb_gray_step_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gray_step_checker_if #(.WIDTH(4), .ERR_CNT_W(8), .WRAP_CNT_W(8)) bus ();
    gray_step_checker #(.WIDTH(4), .ERR_CNT_W(8), .WRAP_CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    // reference model, integer valued
    int m_bin, m_prev_gray, m_valid, m_step, m_sticky, m_errc, m_wrap, m_state;

    function automatic int to_gray(int n);
        return (n ^ (n >> 1)) & 15;
    endfunction

    function automatic int to_bin(int g);
        return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
    endfunction

    function automatic logic [24:0] exp_vec();
        return {4'(m_bin), 1'(m_valid), 1'(m_step), 1'(m_sticky), 8'(m_errc), 8'(m_wrap), 2'(m_state)};
    endfunction

    function automatic logic [24:0] got_vec();
        return {bus.bin_out, bus.bin_valid, bus.step_err, bus.err_sticky, bus.err_count, bus.wrap_count, bus.state};
    endfunction

    task automatic model_reset();
        m_bin = 0; m_prev_gray = 0; m_valid = 0; m_step = 0;
        m_sticky = 0; m_errc = 0; m_wrap = 0; m_state = 0;
    endtask

    task automatic model_step(int g, int s, int c, int r);
        int b;
        if (r != 0) begin
            model_reset();
            return;
        end
        m_valid = 0;
        m_step  = 0;
        if (c != 0) begin
            m_errc = 0; m_sticky = 0;
            if (m_state == 2) m_state = 1;
        end
        if (s != 0) begin
            b = to_bin(g);
            if (m_state == 0) begin
                m_state = 1;
            end else if (g != m_prev_gray) begin
                if ($countones(g ^ m_prev_gray) == 1 && b == (m_bin + 1) % 16) begin
                    if (m_bin == 15) m_wrap = (m_wrap + 1) % 256;
                end else begin
                    m_step = 1; m_sticky = 1; m_state = 2;
                    m_errc = (m_errc + 1 > 255) ? 255 : m_errc + 1;
                end
            end
            m_prev_gray = g;
            m_bin = b;
            m_valid = 1;
        end
    endtask

    task automatic apply(int g, int s, int c, int r);
        bus.gray_in   = 4'(g);
        bus.sample_en = 1'(s);
        bus.clear_err = 1'(c);
        rst           = 1'(r);
        @(posedge clk);
        model_step(g, s, c, r);
        #1;
        bus.sample_en = 1'b0;
        bus.clear_err = 1'b0;
        rst           = 1'b0;
    endtask

    task automatic test_reset();
        apply(0, 1, 1, 1);
        apply(0, 0, 0, 1);
        total++;
        if (got_vec() !== 25'd0) begin
            bad++; $display("FAIL reset_outputs got %h exp %h", got_vec(), 25'd0);
        end
    endtask

    task automatic test_sequence();
        int pulses = 0;
        apply(0, 0, 0, 1);
        for (int i = 0; i <= 16; i++) begin
            apply(to_gray(i % 16), 1, 0, 0);
            total++;
            if (bus.bin_out !== 4'(i % 16)) begin
                bad++; $display("FAIL seq_bin[%0d] got %0d exp %0d", i, bus.bin_out, i % 16);
            end
            if (bus.bin_valid === 1'b1) pulses++;
        end
        total++;
        if (pulses != 17) begin bad++; $display("FAIL seq_pulses got %0d exp 17", pulses); end
        total++;
        if ({bus.wrap_count, bus.err_count, bus.state} !== {8'd1, 8'd0, 2'b01}) begin
            bad++; $display("FAIL seq_final wrap/err/state got %0d/%0d/%0d exp 1/0/1",
                            bus.wrap_count, bus.err_count, bus.state);
        end
    endtask

    task automatic test_double_bit();
        apply(0, 0, 0, 1);
        apply(4'b0000, 1, 0, 0);
        apply(4'b0001, 1, 0, 0);
        apply(4'b0010, 1, 0, 0);
        total++;
        if ({bus.step_err, bus.err_count, bus.err_sticky, bus.state, bus.bin_out} !==
            {1'b1, 8'd1, 1'b1, 2'b10, 4'd3}) begin
            bad++; $display("FAIL double_bit step/cnt/sticky/state/bin got %0d/%0d/%0d/%0d/%0d exp 1/1/1/2/3",
                            bus.step_err, bus.err_count, bus.err_sticky, bus.state, bus.bin_out);
        end
    endtask

    task automatic test_backward();
        apply(0, 0, 0, 1);
        apply(4'b0000, 1, 0, 0);
        apply(4'b0001, 1, 0, 0);
        apply(4'b0011, 1, 0, 0);
        apply(4'b0001, 1, 0, 0);
        total++;
        if ({bus.step_err, bus.err_count, bus.state, bus.bin_out} !== {1'b1, 8'd1, 2'b10, 4'd1}) begin
            bad++; $display("FAIL backward step/cnt/state/bin got %0d/%0d/%0d/%0d exp 1/1/2/1",
                            bus.step_err, bus.err_count, bus.state, bus.bin_out);
        end
    endtask

    task automatic test_hold();
        logic [24:0] snap;
        apply(0, 0, 0, 1);
        apply(4'b0110, 1, 0, 0);
        apply(4'b0110, 1, 0, 0);
        total++;
        if (got_vec() !== exp_vec() || bus.step_err !== 1'b0 || bus.bin_out !== 4'd4) begin
            bad++; $display("FAIL same_gray got %h exp %h", got_vec(), exp_vec());
        end
        snap = exp_vec();
        snap[20] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply(i % 2 == 0 ? 4'b1001 : 4'b0111, 0, 0, 0);
            total++;
            if (got_vec() !== snap) begin
                bad++; $display("FAIL hold[%0d] got %h exp %h", i, got_vec(), snap);
            end
        end
    endtask

    task automatic test_saturate();
        apply(0, 0, 0, 1);
        apply(4'b0000, 1, 0, 0);
        for (int i = 0; i < 300; i++) apply(i % 2 == 0 ? 4'b0011 : 4'b0000, 1, 0, 0);
        total++;
        if (bus.err_count !== 8'd255) begin
            bad++; $display("FAIL saturate got %0d exp 255", bus.err_count);
        end
        apply(4'b0011, 1, 1, 0);
        total++;
        if ({bus.err_count, bus.err_sticky, bus.state, bus.step_err} !== {8'd1, 1'b1, 2'b10, 1'b1}) begin
            bad++; $display("FAIL clear_with_err cnt/sticky/state/step got %0d/%0d/%0d/%0d exp 1/1/2/1",
                            bus.err_count, bus.err_sticky, bus.state, bus.step_err);
        end
        apply(4'b0011, 0, 1, 0);
        total++;
        if ({bus.err_count, bus.err_sticky, bus.state} !== {8'd0, 1'b0, 2'b01}) begin
            bad++; $display("FAIL clear_alone cnt/sticky/state got %0d/%0d/%0d exp 0/0/1",
                            bus.err_count, bus.err_sticky, bus.state);
        end
    endtask

    task automatic test_mid_reset();
        apply(0, 0, 0, 1);
        for (int i = 14; i < 19; i++) apply(to_gray(i % 16), 1, 0, 0);
        apply(4'b0101, 1, 1, 1);
        total++;
        if (got_vec() !== 25'd0) begin
            bad++; $display("FAIL mid_reset got %h exp %h", got_vec(), 25'd0);
        end
        apply(4'b1010, 1, 0, 0);
        total++;
        if ({bus.step_err, bus.err_count, bus.state, bus.bin_out} !== {1'b0, 8'd0, 2'b01, 4'd12}) begin
            bad++; $display("FAIL post_reset_ref step/cnt/state/bin got %0d/%0d/%0d/%0d exp 0/0/1/12",
                            bus.step_err, bus.err_count, bus.state, bus.bin_out);
        end
        apply(4'b0001, 1, 0, 0);
        total++;
        if ({bus.step_err, bus.err_count, bus.state} !== {1'b1, 8'd1, 2'b10}) begin
            bad++; $display("FAIL post_reset_err step/cnt/state got %0d/%0d/%0d exp 1/1/2",
                            bus.step_err, bus.err_count, bus.state);
        end
    endtask

    task automatic test_random();
        int g, s, c, r, k;
        apply(0, 0, 0, 1);
        for (int i = 0; i < 1500; i++) begin
            k = int'($urandom_range(0, 99));
            if (k < 70)      g = to_gray(m_bin + 1);
            else if (k < 80) g = m_prev_gray;
            else if (k < 85) g = to_gray(m_bin + 15);
            else             g = int'($urandom_range(0, 15));
            s = ($urandom_range(0, 9) < 8) ? 1 : 0;
            c = ($urandom_range(0, 19) == 0) ? 1 : 0;
            r = ($urandom_range(0, 199) == 0) ? 1 : 0;
            apply(g, s, c, r);
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL random[%0d] got %h exp %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.gray_in   = '0;
        bus.sample_en = 1'b0;
        bus.clear_err = 1'b0;
        model_reset();
        test_reset();
        test_sequence();
        test_double_bit();
        test_backward();
        test_hold();
        test_saturate();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
